// File: rtl/mnemonic_display_scheduler.sv
// Shares one registered mnemonic decoder across all pipeline stages and streams the
// 5-char mnemonics to a character display. Optional DISP_DIFF_EN sends only stages whose mnemonic changed.
module mnemonic_display_scheduler #(
  parameter int STAGES = 5,
  parameter int ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  snap,
  input  logic [STAGES*32-1:0]  stage_instr,
  output logic [31:0]           dec_instr,
  input  logic [39:0]           dec_char,
  output logic                  char_valid,
  input  logic                  char_ready,
  output logic [7:0]            char_data,
  output logic [ADDR_W-1:0]     char_addr,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [39:0] FILLER = 40'h2D2D2D2020;  // "---  "

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] frame [STAGES];
  logic [KW-1:0] k, k_inc;
  logic [2:0]  i;
  logic [39:0] mnem, mnem_sh, new_mnem;
  logic        pending;

  logic accept, last_char, last_stage, supported, skip;
  logic latch_frame, advance;

  assign accept     = (state == SEND) && char_ready;
  assign last_char  = (i == 3'd4);
  assign last_stage = (k == KW'(STAGES - 1));
  assign k_inc      = k + 1'b1;

  // Only these opcodes are covered by the decoder; anything else would show stale output.
  always_comb begin
    supported = 1'b0;
    unique case (dec_instr[6:0])
      7'b0110011, 7'b1101111, 7'b0110111, 7'b0010111: supported = 1'b1;
      7'b0100011: supported = (dec_instr[14:12] <= 3'd2);
      default:    supported = 1'b0;
    endcase
  end

  assign new_mnem = supported ? dec_char : FILLER;

`ifdef DISP_DIFF_EN
  logic [39:0]       shadow [STAGES];
  logic [STAGES-1:0] shadow_valid;

  always_ff @(posedge clock)
    if (accept && last_char) shadow[k] <= mnem;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n)                 shadow_valid <= '0;
    else if (accept && last_char) shadow_valid[k] <= 1'b1;

  assign skip = shadow_valid[k] && (shadow[k] == new_mnem);
`else
  assign skip = 1'b0;
`endif

  assign latch_frame = ((state == IDLE) && snap) || ((state == DONE) && (pending || snap));
  assign advance     = !last_stage &&
                       (((state == WAIT) && skip) || (accept && last_char));

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (snap) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (skip) state_nxt = last_stage ? DONE : ISSUE;
             else      state_nxt = SEND;
      SEND:  if (accept && last_char) state_nxt = last_stage ? DONE : ISSUE;
      DONE:  state_nxt = (pending || snap) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k         <= '0;
      i         <= '0;
      mnem      <= '0;
      pending   <= 1'b0;
      dec_instr <= '0;
    end else begin
      if (latch_frame) begin
        k         <= '0;
        dec_instr <= stage_instr[31:0];
      end else if (advance) begin
        k         <= k_inc;
        dec_instr <= frame[k_inc];
      end

      if (state == WAIT) begin
        mnem <= new_mnem;
        i    <= '0;
      end else if (accept && !last_char) begin
        i <= i + 3'd1;
      end

      if (state == DONE)                  pending <= 1'b0;
      else if (snap && (state != IDLE))   pending <= 1'b1;
    end
  end

  // NOTE: the frame store has no reset; it is always written before being read.
  always_ff @(posedge clock)
    if (latch_frame)
      for (int s = 0; s < STAGES; s++) frame[s] <= stage_instr[32*s +: 32];

  assign mnem_sh    = mnem << {i, 3'b000};
  assign char_valid = (state == SEND);
  assign char_data  = char_valid ? mnem_sh[39:32] : 8'h00;
  assign char_addr  = char_valid ? (ADDR_W'(k) * ADDR_W'(3'd5) + ADDR_W'(i)) : '0;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_mnemonic_display_scheduler.sv
// Scoreboard bench for mnemonic_display_scheduler: stimulus pushes expected bytes,
// a monitor pops them on every accepted byte and checks hold stability while stalled.
module tb_mnemonic_display_scheduler;

  localparam int STAGES = 5;
  localparam int ADDR_W = 5;

  typedef logic [39:0] mnem_t;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 snap;
  logic [STAGES*32-1:0] stage_instr;
  logic [31:0]          dec_instr;
  logic [39:0]          dec_char;
  logic                 char_valid;
  logic                 char_ready = 1'b1;
  logic [7:0]           char_data;
  logic [ADDR_W-1:0]    char_addr;
  logic                 busy;
  logic                 frame_done;

  mnemonic_display_scheduler #(.STAGES(STAGES), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .snap(snap), .stage_instr(stage_instr),
    .dec_instr(dec_instr), .dec_char(dec_char), .char_valid(char_valid),
    .char_ready(char_ready), .char_data(char_data), .char_addr(char_addr),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  // Registered decoder stand-in; unsupported words produce a non-filler string.
  function automatic mnem_t tb_decode(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return w[30] ? "SUB  " : "ADD  ";
      7'b0110111: return "LUI  ";
      7'b0010111: return "AUIPC";
      7'b1101111: return "JAL  ";
      7'b0100011: return "SW   ";
      7'b0000011: return "LW   ";
      default:    return "?????";
    endcase
  endfunction

  always @(posedge clock) dec_char <= tb_decode(dec_instr);

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit rand_ready = 1'b0;
  logic [ADDR_W+7:0] exp_q [$];
  mnem_t exp_m [STAGES];
`ifdef DISP_DIFF_EN
  mnem_t m_shadow [STAGES];
  bit    m_valid  [STAGES];
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    mnem_t m;
    for (int k = 0; k < STAGES; k++) begin
`ifdef DISP_DIFF_EN
      if (m_valid[k] && m_shadow[k] == exp_m[k]) continue;
      m_shadow[k] = exp_m[k];
      m_valid[k]  = 1'b1;
`endif
      m = exp_m[k];
      for (int i = 0; i < 5; i++)
        exp_q.push_back({ADDR_W'(k * 5 + i), m[39 - 8*i -: 8]});
    end
    exp_done++;
  endtask

  task automatic set_stages(input logic [31:0] w0, w1, w2, w3, w4);
    stage_instr = {w4, w3, w2, w1, w0};
  endtask

  task automatic do_snap();
    @(posedge clock); #1 snap = 1'b1;
    @(posedge clock); #1 snap = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clock); n++; end
    check("frame_timeout", {63'd0, busy}, 64'd0);
    @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(exp_done));
  endtask

  // Ready driver: held high unless the random stall phase is active.
  initial forever begin
    @(posedge clock); #1;
    char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: every byte seen valid&ready at the negedge is accepted at the next posedge.
  initial begin
    bit hold_v = 1'b0;
    logic [ADDR_W+7:0] hold_b = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin hold_v = 1'b0; continue; end
      if (hold_v)
        check("hold_stable", {char_valid, char_addr, char_data}, {1'b1, hold_b});
      hold_v = 1'b0;
      if (char_valid) begin
        if (char_ready) begin
          if (exp_q.size() == 0)
            check("unexpected_byte", {char_addr, char_data}, '0 - 1);
          else
            check("byte", {char_addr, char_data}, exp_q.pop_front());
        end else begin
          hold_v = 1'b1;
          hold_b = {char_addr, char_data};
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    reset_n = 1'b0;
    snap    = 1'b0;
    set_stages(0, 0, 0, 0, 0);
`ifdef DISP_DIFF_EN
    foreach (m_valid[k]) m_valid[k] = 1'b0;
`endif
    #23;
    check("rst_char_valid", {63'd0, char_valid}, 64'd0);
    check("rst_char_data", 64'(char_data), 64'd0);
    check("rst_char_addr", 64'(char_addr), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Frame 1: all ADD, exact latency from the snap edge E0.
    set_stages(32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533);
    exp_m = '{"ADD  ", "ADD  ", "ADD  ", "ADD  ", "ADD  "};
    push_frame();
    @(posedge clock); #1 snap = 1'b1;
    @(posedge clock); #1 snap = 1'b0;         // E0
    check("busy_after_snap", {63'd0, busy}, 64'd1);
    @(posedge clock);                          // E1
    @(negedge clock);
    check("no_valid_before_E2", {63'd0, char_valid}, 64'd0);
    @(posedge clock);                          // E2
    @(negedge clock);
    check("valid_after_E2", {63'd0, char_valid}, 64'd1);
    check("first_addr", 64'(char_addr), 64'd0);
    repeat (32) @(posedge clock);              // E34
    @(negedge clock);
    check("no_done_after_E34", {63'd0, frame_done}, 64'd0);
    @(posedge clock);                          // E35
    @(negedge clock);
    check("done_after_E35", {63'd0, frame_done}, 64'd1);
    @(negedge clock);
    check("busy_low_after", {63'd0, busy}, 64'd0);
    check("done_one_cycle", {63'd0, frame_done}, 64'd0);
    check("queue_empty_f1", 64'(exp_q.size()), 64'd0);

    // Frame 2: mixed supported and unsupported words.
    set_stages(32'h00B50533, 32'h40B50533, 32'h00002083, 32'h000000B7, 32'h00112023);
    exp_m = '{"ADD  ", "SUB  ", "---  ", "LUI  ", "SW   "};
    push_frame();
    do_snap();
    wait_idle(200);

    // Frame 3: remaining opcode classes with random display stalls.
    set_stages(32'h0000006F, 32'h00000097, 32'h00003023, 32'h00000013, 32'h00B50533);
    exp_m = '{"JAL  ", "AUIPC", "---  ", "---  ", "ADD  "};
    push_frame();
    rand_ready = 1'b1;
    do_snap();
    wait_idle(400);
    rand_ready = 1'b0;
    repeat (2) @(posedge clock);

    // Three requests mid-frame collapse to one extra frame using the words present at DONE.
    set_stages(32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533);
    exp_m = '{"ADD  ", "ADD  ", "ADD  ", "ADD  ", "ADD  "};
    push_frame();
    do_snap();
    repeat (3) begin
      repeat (3) @(posedge clock);
      #1 snap = 1'b1;
      @(posedge clock); #1 snap = 1'b0;
    end
    set_stages(32'h40B50533, 32'h40B50533, 32'h40B50533, 32'h40B50533, 32'h40B50533);
    exp_m = '{"SUB  ", "SUB  ", "SUB  ", "SUB  ", "SUB  "};
    push_frame();
    wait_idle(300);
    repeat (20) @(negedge clock);
    check("no_third_frame_busy", {63'd0, busy}, 64'd0);
    check("no_third_frame_done", 64'(done_cnt), 64'(exp_done));

    // Reset during stage 3: immediate abort, no frame_done, next frame restarts at addr 0.
    set_stages(32'h000000B7, 32'h000000B7, 32'h000000B7, 32'h000000B7, 32'h000000B7);
    exp_m = '{"LUI  ", "LUI  ", "LUI  ", "LUI  ", "LUI  "};
    push_frame();
    exp_done--;
    do_snap();
    begin
      int n = 0;
      while (!(char_valid && char_addr == ADDR_W'(15)) && n < 100) begin
        @(negedge clock); n++;
      end
      check("reach_stage3", 64'(char_addr), 64'd15);
    end
    #2 reset_n = 1'b0;
    #1;
    check("abort_valid_low", {63'd0, char_valid}, 64'd0);
    check("abort_busy_low", {63'd0, busy}, 64'd0);
    exp_q.delete();
`ifdef DISP_DIFF_EN
    foreach (m_valid[k]) m_valid[k] = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_no_done", 64'(done_cnt), 64'(exp_done));
    check("abort_idle", {63'd0, busy}, 64'd0);
    push_frame();
    do_snap();
    wait_idle(200);

    // Identical frames, then only stage 4 changes.
    set_stages(32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533);
    exp_m = '{"ADD  ", "ADD  ", "ADD  ", "ADD  ", "ADD  "};
    push_frame();
    do_snap();
    wait_idle(200);
    push_frame();
    do_snap();
    wait_idle(200);
    set_stages(32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h00B50533, 32'h000000B7);
    exp_m = '{"ADD  ", "ADD  ", "ADD  ", "ADD  ", "LUI  "};
    push_frame();
    do_snap();
    wait_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
